// File: rtl/vsa_param_core.sv
// vsa_param_core
//   Parametrised non-pipelined VSA core. A five-state FSM runs
//   IF -> ID -> EX -> MEM -> WB for every instruction. IF waits while
//   imem_ready is low. MEM waits while dmem_ready is low, but only for LW/SW.
//
//   Handshake: a memory transfer completes on a rising clock edge where the
//   core is requesting (IF, or MEM with rd/wr high) and the matching ready is 1.
//   While ready is 0 the request and its address/data stay stable.
//
// Ports
//   clock        master clock, rising edge
//   reset_n      asynchronous active-low reset
//   pc           instruction address (valid in IF)
//   instruction  instruction word, captured in IF when imem_ready=1
//   imem_ready   instruction port ready
//   alu_output   data address for LW/SW, otherwise the ALU result register
//   datain       load data, captured in MEM when dmem_ready=1
//   dataout      store data (B register)
//   wr / rd      store / load strobes, high throughout MEM of SW / LW
//   dmem_ready   data port ready
module vsa_param_core #(
  parameter int DW     = 5,
  parameter int NREG   = 4,
  parameter int PW     = 5,
  parameter int PC_INC = 2,
  localparam int RB    = $clog2(NREG),
  localparam int IMMW  = RB + 3,
  localparam int IW    = 3 * RB + 6
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic [PW-1:0] pc,
  input  logic [IW-1:0] instruction,
  input  logic          imem_ready,
  output logic [DW-1:0] alu_output,
  input  logic [DW-1:0] datain,
  output logic [DW-1:0] dataout,
  output logic          wr,
  output logic          rd,
  input  logic          dmem_ready
);

  // Encoding is fixed so the state can be read back as IF=0 .. WB=4.
  typedef enum logic [2:0] {
    IF_ST  = 3'd0,
    ID_ST  = 3'd1,
    EX_ST  = 3'd2,
    MEM_ST = 3'd3,
    WB_ST  = 3'd4
  } stateT;

  localparam logic [2:0] OP_LW   = 3'd0;
  localparam logic [2:0] OP_SW   = 3'd1;
  localparam logic [2:0] OP_BEQZ = 3'd2;
  localparam logic [2:0] OP_ALU  = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_SUBI = 3'd5;

  stateT state, nextState;

  logic [DW-1:0] regFile [NREG];
  logic [PW-1:0] pcReg, npc;
  logic [IW-1:0] ir;
  logic [DW-1:0] a, b, aluOut, lmd;
  logic          cond;

  // Field decode from the instruction register.
  logic [2:0]      opcode, fun;
  logic [RB-1:0]   rs1, rs2, rdField;
  logic [IMMW-1:0] imm, brOff;
  logic [DW-1:0]   immDw, brTarget, aluResult;
  logic            memOp, memDone;

  assign opcode   = ir[IW-1 -: 3];
  assign rs1      = ir[IW-4 -: RB];
  assign rs2      = ir[IW-4-RB -: RB];
  assign rdField  = ir[IW-4-2*RB -: RB];
  assign fun      = ir[2:0];
  assign imm      = ir[IMMW-1:0];
  assign immDw    = DW'(imm);
  assign brOff    = {imm[IMMW-2:0], 1'b0};
  assign brTarget = DW'(npc) + DW'(brOff);

  assign memOp   = (opcode == OP_LW) || (opcode == OP_SW);
  // Non-memory ops leave MEM after one cycle regardless of dmem_ready.
  assign memDone = !memOp || dmem_ready;

  // Shifts move by a single bit position; B is not used as a shift amount.
  always_comb begin
    aluResult = '0;
    case (fun)
      3'd0: aluResult = a + b;
      3'd1: aluResult = a - b;
      3'd2: aluResult = a & b;
      3'd3: aluResult = a | b;
      3'd4: aluResult = a ^ b;
      3'd5: aluResult = ~a;
      3'd6: aluResult = a >> 1;
      3'd7: aluResult = {a[DW-1], a[DW-1:1]};
      default: aluResult = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IF_ST;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IF_ST:   if (imem_ready) nextState = ID_ST;
      ID_ST:   nextState = EX_ST;
      EX_ST:   nextState = MEM_ST;
      MEM_ST:  if (memDone) nextState = WB_ST;
      WB_ST:   nextState = IF_ST;
      default: nextState = IF_ST;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regFile[i] <= '0;
      pcReg  <= '0;
      npc    <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluOut <= '0;
      cond   <= 1'b0;
      lmd    <= '0;
    end else begin
      case (state)
        IF_ST: begin
          if (imem_ready) begin
            ir  <= instruction;
            npc <= pcReg + PW'(PC_INC);
          end
        end
        ID_ST: begin
          a <= (rs1 == '0) ? '0 : regFile[rs1];
          b <= (rs2 == '0) ? '0 : regFile[rs2];
        end
        EX_ST: begin
          case (opcode)
            OP_LW, OP_SW, OP_ADDI: aluOut <= a + immDw;
            OP_SUBI:               aluOut <= a - immDw;
            OP_ALU:                aluOut <= aluResult;
            OP_BEQZ: begin
              aluOut <= brTarget;
              cond   <= (a == '0);
            end
            default: ;
          endcase
        end
        MEM_ST: begin
          if (memDone) begin
            if (opcode == OP_LW) lmd <= datain;
            pcReg <= ((opcode == OP_BEQZ) && cond) ? PW'(aluOut) : npc;
          end
        end
        WB_ST: begin
          // Index 0 is never written, so R0 stays zero.
          case (opcode)
            OP_ALU:           if (rdField != '0) regFile[rdField] <= aluOut;
            OP_ADDI, OP_SUBI: if (rs2 != '0) regFile[rs2] <= aluOut;
            OP_LW:            if (rs2 != '0) regFile[rs2] <= lmd;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign pc         = pcReg;
  assign alu_output = aluOut;
  assign dataout    = b;
  assign wr         = (state == MEM_ST) && (opcode == OP_SW);
  assign rd         = (state == MEM_ST) && (opcode == OP_LW);

endmodule

// File: tb/tb_vsa_param_core.sv
// tb_vsa_param_core
//   Bench for vsa_param_core at default parameters (DW=5, NREG=4, PW=5).
//   A table of instructions, each with its expected register result and
//   next pc, is applied in order. Expected results go into exp_q when an
//   instruction is driven and are popped when the instruction leaves WB.
module tb_vsa_param_core;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  pc;
  logic [11:0] instruction = '0;
  logic        imem_ready = 1'b0;
  logic [4:0]  alu_output;
  logic [4:0]  datain = '0;
  logic [4:0]  dataout;
  logic        wr, rd;
  logic        dmem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // {expReg(5), expPc(5), cycles(8), strobeCycles(8)}
  logic [25:0] exp_q[$];

  vsa_param_core dut (
    .clock(clock), .reset_n(reset_n), .pc(pc), .instruction(instruction),
    .imem_ready(imem_ready), .alu_output(alu_output), .datain(datain),
    .dataout(dataout), .wr(wr), .rd(rd), .dmem_ready(dmem_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int reg_val(input int idx);
    return int'(dut.regFile[idx]);
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n    = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_pc", int'(pc), 0);
    chk("reset_alu_output", int'(alu_output), 0);
    chk("reset_dataout", int'(dataout), 0);
    chk("reset_wr_rd", int'({wr, rd}), 0);
    chk("reset_state", int'(dut.state), 0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [11:0] enc_i(input int op, input int rs1, input int rdst, input int imm);
    logic [2:0] o = 3'(op);
    logic [1:0] s = 2'(rs1);
    logic [1:0] d = 2'(rdst);
    logic [4:0] i = 5'(imm);
    return {o, s, d, i};
  endfunction

  function automatic logic [11:0] enc_r(input int rs1, input int rs2, input int rdst, input int fn);
    logic [1:0] s1 = 2'(rs1);
    logic [1:0] s2 = 2'(rs2);
    logic [1:0] d  = 2'(rdst);
    logic [2:0] f  = 3'(fn);
    return {3'd3, s1, s2, d, f};
  endfunction

  // ---------------- driver + scoreboard pop ----------------
  // Runs one instruction from IF to WB exit. Must be entered with the core in IF.
  task automatic run_instr(input logic [11:0] instr, input int ridx, input int exp_reg,
                           input int exp_pc, input int imem_wait, input int dmem_wait,
                           input logic [4:0] din, input int exp_addr, input string tag);
    int op = int'(instr[11:9]);
    bit mem_op = (op == 0) || (op == 1);
    int cycles = 0, strobes = 0, if_cnt = 0, mem_cnt = 0, st = 0, prev_st = 0;
    int addr_seen = -1;
    logic [25:0] e, got;
    exp_q.push_back({5'(exp_reg), 5'(exp_pc), 8'(5 + imem_wait + (mem_op ? dmem_wait : 0)),
                     8'(mem_op ? dmem_wait + 1 : 0)});
    instruction = instr;
    datain      = din;
    forever begin
      @(negedge clock);
      st = int'(dut.state);
      imem_ready = (st == 0) && (if_cnt >= imem_wait);
      if (st == 0) if_cnt++;
      dmem_ready = 1'b0;
      if (st == 3) begin
        dmem_ready = (mem_cnt >= dmem_wait);
        mem_cnt++;
        if (rd || wr) strobes++;
        addr_seen = int'(alu_output);
      end
      prev_st = st;
      @(posedge clock);
      #1;
      cycles++;
      if (prev_st == 4) break;
      if (cycles > 60) begin
        chk({tag, "_timeout"}, cycles, 0);
        break;
      end
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    e   = exp_q.pop_front();
    got = {5'(reg_val(ridx)), pc, 8'(cycles), 8'(strobes)};
    chk({tag, "_reg"}, int'(got[25:21]), int'(e[25:21]));
    chk({tag, "_pc"}, int'(got[20:16]), int'(e[20:16]));
    chk({tag, "_cycles"}, int'(got[15:8]), int'(e[15:8]));
    chk({tag, "_strobe_cycles"}, int'(got[7:0]), int'(e[7:0]));
    chk({tag, "_state_if"}, int'(dut.state), 0);
    if (mem_op) chk({tag, "_addr"}, addr_seen, exp_addr);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [11:0] instr;
    int          ridx;
    int          exp_reg;
    int          exp_pc;
    int          dmem_wait;
    logic [4:0]  din;
    int          exp_addr;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic [11:0] instr, input int ridx, input int exp_reg,
                              input int exp_pc, input int dw, input int din, input int addr);
    vec_t v;
    v.instr = instr; v.ridx = ridx; v.exp_reg = exp_reg; v.exp_pc = exp_pc;
    v.dmem_wait = dw; v.din = 5'(din); v.exp_addr = addr;
    return v;
  endfunction

  initial begin
    // Table starts from reset: pc=0, all registers 0.
    vecs[0]  = mk(enc_i(4, 0, 1, 7),  1, 7,    2,  0, 0, 0);  // ADDI R1,R0,7
    vecs[1]  = mk(enc_i(2, 0, 0, 3),  0, 0,    10, 0, 0, 0);  // BEQZ R0 taken: 4+6
    vecs[2]  = mk(enc_i(2, 1, 0, 3),  1, 7,    12, 0, 0, 0);  // BEQZ R1 not taken
    vecs[3]  = mk(enc_i(4, 0, 1, 31), 1, 31,   14, 0, 0, 0);  // ADDI R1,R0,31
    vecs[4]  = mk(enc_i(4, 1, 1, 1),  1, 0,    16, 0, 0, 0);  // ADDI wraps to 0
    vecs[5]  = mk(enc_i(5, 0, 0, 1),  0, 0,    18, 0, 0, 0);  // SUBI R0 dropped
    vecs[6]  = mk(enc_i(4, 0, 1, 22), 1, 22,   20, 0, 0, 0);  // A = 10110
    vecs[7]  = mk(enc_i(4, 0, 2, 12), 2, 12,   22, 0, 0, 0);  // B = 01100
    vecs[8]  = mk(enc_r(1, 2, 3, 0),  3, 'h02, 24, 0, 0, 0);  // ADD
    vecs[9]  = mk(enc_r(1, 2, 3, 1),  3, 'h0A, 26, 0, 0, 0);  // SUB
    vecs[10] = mk(enc_r(1, 2, 3, 2),  3, 'h04, 28, 0, 0, 0);  // AND
    vecs[11] = mk(enc_r(1, 2, 3, 3),  3, 'h1E, 30, 0, 0, 0);  // OR
    vecs[12] = mk(enc_r(1, 2, 3, 4),  3, 'h1A, 0,  0, 0, 0);  // XOR, pc wraps
    vecs[13] = mk(enc_r(1, 2, 3, 5),  3, 'h09, 2,  0, 0, 0);  // NOT
    vecs[14] = mk(enc_r(1, 2, 3, 6),  3, 'h0B, 4,  0, 0, 0);  // SRL
    vecs[15] = mk(enc_r(1, 2, 3, 7),  3, 'h1B, 6,  0, 0, 0);  // SRA
    vecs[16] = mk(enc_r(1, 2, 0, 0),  0, 0,    8,  0, 0, 0);  // ALU to R0 dropped
    vecs[17] = mk(enc_i(6, 1, 3, 0),  3, 'h1B, 10, 2, 0, 0);  // NOP, dmem_ready ignored
    vecs[18] = mk(enc_i(2, 0, 0, 31), 0, 0,    10, 0, 0, 0);  // BEQZ 12+30 wraps to 10
    vecs[19] = mk(enc_i(1, 0, 1, 4),  1, 22,   12, 2, 0, 4);  // SW R1,[R0+4]
    vecs[20] = mk(enc_i(0, 0, 2, 4),  2, 'h15, 14, 3, 'h15, 4); // LW R2,[R0+4]
    vecs[21] = mk(enc_i(5, 2, 2, 22), 2, 31,   16, 0, 0, 0);  // SUBI 21-22 wraps
    vecs[22] = mk(enc_i(7, 2, 2, 9),  2, 31,   18, 0, 0, 0);  // NOP opcode 7
    vecs[23] = mk(enc_i(0, 1, 0, 1),  0, 0,    20, 1, 7, 23); // LW to R0 dropped
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    // Test 1: ADDI R1,R0,7 with no wait states.
    do_reset();
    run_instr(12'h827, 1, 7, 2, 0, 0, 5'd0, 0, "addi_r1_7");

    // Test 2: BEQZ R0,3 at pc=0 is taken to 8.
    do_reset();
    run_instr(12'h403, 0, 0, 8, 0, 0, 5'd0, 0, "beqz_r0_pc0");
    chk("beqz_cond", int'(dut.cond), 1);

    // Table-driven run with random instruction-port wait states.
    do_reset();
    foreach (vecs[i]) begin
      run_instr(vecs[i].instr, vecs[i].ridx, vecs[i].exp_reg, vecs[i].exp_pc,
                $urandom_range(0, 2), vecs[i].dmem_wait, vecs[i].din, vecs[i].exp_addr,
                $sformatf("vec%0d", i));
    end

    // Test 3: LW R2,[R0+4], 3 wait cycles: 8 clocks total, rd high for 4.
    do_reset();
    run_instr(enc_i(0, 0, 2, 4), 2, 'h15, 2, 0, 3, 5'h15, 4, "lw_wait3");

    // Test 6: reset during MEM of a stalled SW.
    do_reset();
    run_instr(enc_i(4, 0, 1, 5), 1, 5, 2, 0, 0, 5'd0, 0, "addi_r1_5");
    instruction = enc_i(1, 0, 1, 2);  // SW R1,[R0+2]
    imem_ready  = 1'b1;
    dmem_ready  = 1'b0;
    n = 0;
    while (!wr && n < 20) begin
      @(negedge clock);
      n++;
    end
    imem_ready = 1'b0;
    chk("sw_wr_seen", int'(wr), 1);
    chk("sw_addr", int'(alu_output), 2);
    chk("sw_dataout", int'(dataout), 5);
    @(posedge clock);
    #1;
    chk("sw_wr_held", int'(wr), 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_wr_drop", int'(wr), 0);
    chk("abort_pc", int'(pc), 0);
    chk("abort_state", int'(dut.state), 0);
    chk("abort_r1", reg_val(1), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("release_state", int'(dut.state), 0);
    chk("release_pc", int'(pc), 0);
    chk("release_wr", int'(wr), 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "global timeout");
  end

endmodule
